// File: rtl/arilla_pkg.sv
// Shared types and helpers for the arilla bus master.
// Build option: ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN enables split word-crossing accesses.
package arilla_pkg;

    localparam int ByteSize = 8;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ACCESS2 = 2'd2,
        RESP    = 2'd3
    } master_state_e;

    // Unshifted byte-enable mask for an access size; illegal sizes enable nothing.
    function automatic logic [3:0] size_to_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Arilla bus: word-addressed, byte-enabled, with a shared tri-state data bus
// resolved here from the master and slave drive enables.
interface arilla_bus_if #(
    parameter int DataWidth        = 32,
    parameter int ByteAddressWidth = 32
);
    localparam int BytesPerWord     = DataWidth / 8;
    localparam int WordAddressWidth = ByteAddressWidth - $clog2(BytesPerWord);

    logic [WordAddressWidth-1:0] address;
    logic [BytesPerWord-1:0]     byte_enable;
    logic                        read;
    logic                        write;
    logic                        available;
    logic                        intercept;
    logic [DataWidth-1:0]        master_data;
    logic                        master_data_en;
    logic [DataWidth-1:0]        slave_data;
    logic                        slave_data_en;
    wire  [DataWidth-1:0]        data;

    assign data = master_data_en ? master_data :
                  (slave_data_en ? slave_data : {DataWidth{1'bz}});

    modport master (
        output address, byte_enable, read, write, master_data, master_data_en,
        input  data, available, intercept
    );

    modport slave (
        input  address, byte_enable, read, write, data,
        output available, intercept, slave_data, slave_data_en
    );

endinterface

// File: rtl/arilla_bus_lane_align.sv
// Lane alignment for the arilla master: places write data/byte enables in a
// two-word window and extracts/extends read data from it.
module arilla_bus_lane_align
    import arilla_pkg::*;
#(
    parameter  int DataWidth    = 32,
    localparam int BytesPerWord = DataWidth / ByteSize,
    localparam int OffW         = $clog2(BytesPerWord)
) (
    input  logic [OffW-1:0]         offset_i,
    input  logic [1:0]              size_i,
    input  logic                    unsigned_i,
    input  logic                    hi_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [DataWidth-1:0]    rword0_i,
    input  logic [DataWidth-1:0]    rword1_i,
    output logic [BytesPerWord-1:0] be_o,
    output logic [DataWidth-1:0]    wdata_o,
    output logic                    cross_o,
    output logic [DataWidth-1:0]    rdata_o
);

    logic [2*BytesPerWord-1:0] be_wide_s;
    logic [2*DataWidth-1:0]    wdata_wide_s;
    logic [2*DataWidth-1:0]    rdata_wide_s;
    logic [DataWidth-1:0]      rshift_s;
    logic [DataWidth-1:0]      rmask_s;
    logic                      sign_s;
    int unsigned               nbits_s;

    // Write side: hi_i selects the second word of a crossing access.
    always_comb begin
        be_wide_s    = (2*BytesPerWord)'(size_to_mask(size_i)) << offset_i;
        wdata_wide_s = (2*DataWidth)'(wdata_i) << (ByteSize * int'(offset_i));
        cross_o      = |be_wide_s[2*BytesPerWord-1:BytesPerWord];
        if (hi_i) begin
            be_o    = be_wide_s[2*BytesPerWord-1:BytesPerWord];
            wdata_o = wdata_wide_s[2*DataWidth-1:DataWidth];
        end else begin
            be_o    = be_wide_s[BytesPerWord-1:0];
            wdata_o = wdata_wide_s[DataWidth-1:0];
        end
    end

    // Read side: mask^(mask>>1) isolates the sign bit position without indexing.
    always_comb begin
        rdata_wide_s = {rword1_i, rword0_i} >> (ByteSize * int'(offset_i));
        rshift_s     = rdata_wide_s[DataWidth-1:0];
        nbits_s      = ByteSize * $countones(size_to_mask(size_i));
        rmask_s      = ~({DataWidth{1'b1}} << nbits_s);
        sign_s       = |(rshift_s & (rmask_s ^ (rmask_s >> 1)));
        rdata_o      = (unsigned_i || !sign_s) ? (rshift_s & rmask_s) : (rshift_s | ~rmask_s);
    end

endmodule

// File: rtl/arilla_bus_master.sv
// Arilla bus master: byte-addressed load/store requests to word-addressed bus
// transactions. Split accesses need ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN.
module arilla_bus_master
    import arilla_pkg::*;
#(
    parameter int DataWidth        = 32,
    parameter int ByteAddressWidth = 32,
    parameter int TimeoutCycles    = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ByteAddressWidth-1:0] req_addr,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsigned,
    input  logic [DataWidth-1:0]        req_wdata,
    output logic                        rsp_valid,
    output logic [DataWidth-1:0]        rsp_rdata,
    output logic                        rsp_error,
    output logic                        rsp_intercepted,
    arilla_bus_if.master                bus
);

    localparam int BytesPerWord = DataWidth / ByteSize;
    localparam int OffW         = $clog2(BytesPerWord);
    localparam int WordAddrW    = ByteAddressWidth - OffW;
    localparam int CntW         = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    master_state_e            state_q, state_d;
    logic                     write_q, write_d;
    logic [OffW-1:0]          offset_q, offset_d;
    logic [1:0]               size_q, size_d;
    logic                     unsigned_q, unsigned_d;
    logic [DataWidth-1:0]     wdata_q, wdata_d;
    logic                     icpt_q, icpt_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic [WordAddrW-1:0]     baddr_q, baddr_d;
    logic [BytesPerWord-1:0]  be_q, be_d;
    logic [DataWidth-1:0]     bdata_q, bdata_d;
    logic                     bdata_en_q, bdata_en_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_error_q, rsp_error_d;
    logic                     rsp_icpt_q, rsp_icpt_d;
`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
    logic [DataWidth-1:0]     word0_q, word0_d;
`endif

    logic                     sel_req_s;
    logic                     la_hi_s;
    logic [DataWidth-1:0]     la_rword0_s, la_rword1_s;
    logic [BytesPerWord-1:0]  la_be_s;
    logic [DataWidth-1:0]     la_wdata_s, la_rdata_s;
    logic                     la_cross_s;
    logic                     req_err_s;
    logic                     tmo_hit_s;
    logic                     done_ok_s, done_tmo_s;

    assign sel_req_s = (state_q == IDLE);
    assign tmo_hit_s = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));

`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
    assign la_hi_s     = ~sel_req_s;
    assign la_rword0_s = (state_q == ACCESS2) ? word0_q : bus.data;
    assign la_rword1_s = (state_q == ACCESS2) ? bus.data : {DataWidth{1'b0}};
    assign req_err_s   = (req_size == 2'd3);
`else
    logic [OffW-1:0] align_mask_s;

    // Without splitting, any address not a multiple of the size is refused.
    always_comb begin
        case (req_size)
            SIZE_BYTE: align_mask_s = OffW'(0);
            SIZE_HALF: align_mask_s = OffW'(1);
            SIZE_WORD: align_mask_s = OffW'(3);
            default:   align_mask_s = OffW'(0);
        endcase
    end

    assign la_hi_s     = 1'b0;
    assign la_rword0_s = bus.data;
    assign la_rword1_s = {DataWidth{1'b0}};
    assign req_err_s   = (req_size == 2'd3) || ((req_addr[OffW-1:0] & align_mask_s) != OffW'(0))
                         || la_cross_s;
`endif

    arilla_bus_lane_align #(
        .DataWidth (DataWidth)
    ) u_lane_align (
        .offset_i   (sel_req_s ? req_addr[OffW-1:0] : offset_q),
        .size_i     (sel_req_s ? req_size : size_q),
        .unsigned_i (sel_req_s ? req_unsigned : unsigned_q),
        .hi_i       (la_hi_s),
        .wdata_i    (sel_req_s ? req_wdata : wdata_q),
        .rword0_i   (la_rword0_s),
        .rword1_i   (la_rword1_s),
        .be_o       (la_be_s),
        .wdata_o    (la_wdata_s),
        .cross_o    (la_cross_s),
        .rdata_o    (la_rdata_s)
    );

    // Next-state, bus drive and response generation.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        offset_d    = offset_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        wdata_d     = wdata_q;
        icpt_d      = icpt_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        baddr_d     = baddr_q;
        be_d        = be_q;
        bdata_d     = bdata_q;
        bdata_en_d  = bdata_en_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = {DataWidth{1'b0}};
        rsp_error_d = 1'b0;
        rsp_icpt_d  = 1'b0;
        done_ok_s   = 1'b0;
        done_tmo_s  = 1'b0;
`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
        word0_d     = word0_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    offset_d   = req_addr[OffW-1:0];
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    icpt_d     = 1'b0;
                    cnt_d      = {CntW{1'b0}};
                    if (req_err_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        rd_d       = ~req_write;
                        wr_d       = req_write;
                        baddr_d    = req_addr[ByteAddressWidth-1:OffW];
                        be_d       = la_be_s;
                        bdata_d    = req_write ? la_wdata_s : {DataWidth{1'b0}};
                        bdata_en_d = req_write;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (bus.available) begin
                    icpt_d = icpt_q | bus.intercept;
`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
                    if (la_cross_s) begin
                        state_d = ACCESS2;
                        word0_d = bus.data;
                        baddr_d = baddr_q + WordAddrW'(1);
                        be_d    = la_be_s;
                        bdata_d = write_q ? la_wdata_s : {DataWidth{1'b0}};
                        cnt_d   = {CntW{1'b0}};
                    end else begin
                        done_ok_s = 1'b1;
                    end
`else
                    done_ok_s = 1'b1;
`endif
                end else if (tmo_hit_s) begin
                    done_tmo_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
            ACCESS2: begin
                if (bus.available) begin
                    done_ok_s = 1'b1;
                end else if (tmo_hit_s) begin
                    done_tmo_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_ok_s || done_tmo_s) begin
            state_d     = RESP;
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            baddr_d     = {WordAddrW{1'b0}};
            be_d        = {BytesPerWord{1'b0}};
            bdata_d     = {DataWidth{1'b0}};
            bdata_en_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_error_d = done_tmo_s;
            rsp_icpt_d  = done_tmo_s ? icpt_q : (icpt_q | bus.intercept);
            rsp_rdata_d = (done_tmo_s || write_q) ? {DataWidth{1'b0}} : la_rdata_s;
        end else begin
            rsp_icpt_d = rsp_icpt_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            offset_q    <= {OffW{1'b0}};
            size_q      <= 2'd0;
            unsigned_q  <= 1'b0;
            wdata_q     <= {DataWidth{1'b0}};
            icpt_q      <= 1'b0;
            cnt_q       <= {CntW{1'b0}};
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            baddr_q     <= {WordAddrW{1'b0}};
            be_q        <= {BytesPerWord{1'b0}};
            bdata_q     <= {DataWidth{1'b0}};
            bdata_en_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DataWidth{1'b0}};
            rsp_error_q <= 1'b0;
            rsp_icpt_q  <= 1'b0;
`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
            word0_q     <= {DataWidth{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
            icpt_q      <= icpt_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            baddr_q     <= baddr_d;
            be_q        <= be_d;
            bdata_q     <= bdata_d;
            bdata_en_q  <= bdata_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            rsp_icpt_q  <= rsp_icpt_d;
`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
            word0_q     <= word0_d;
`endif
        end
    end

    assign req_ready          = (state_q == IDLE);
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_error          = rsp_error_q;
    assign rsp_intercepted    = rsp_icpt_q;
    assign bus.read           = rd_q;
    assign bus.write          = wr_q;
    assign bus.address        = baddr_q;
    assign bus.byte_enable    = be_q;
    assign bus.master_data    = bdata_q;
    assign bus.master_data_en = bdata_en_q;

endmodule

// File: tb/tb_arilla_bus_master.sv
// Directed self-checking bench for arilla_bus_master (DataWidth 32, TimeoutCycles 4).
module tb_arilla_bus_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_intercepted;
    int          checks;
    int          errors;

    arilla_bus_if #(.DataWidth(32), .ByteAddressWidth(32)) bus ();

    arilla_bus_master #(
        .DataWidth        (32),
        .ByteAddressWidth (32),
        .TimeoutCycles    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .rsp_intercepted (rsp_intercepted),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns in the first cycle after acceptance.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic slave(input logic avail, input logic icpt, input logic drive, input logic [31:0] d);
        bus.available = avail; bus.intercept = icpt;
        bus.slave_data_en = drive; bus.slave_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        checks++; if ({rsp_error, rsp_intercepted} !== 2'b00) begin errors++; $display("FAIL reset_err_icpt: got %b expected 00", {rsp_error, rsp_intercepted}); end
        checks++; if ({bus.read, bus.write} !== 2'b00) begin errors++; $display("FAIL reset_rw: got %b expected 00", {bus.read, bus.write}); end
        checks++; if (bus.address !== 30'h0 || bus.byte_enable !== 4'h0) begin errors++; $display("FAIL reset_addr_be: got %h/%b expected 0/0000", bus.address, bus.byte_enable); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word_load();
        issue(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0);
        checks++; if ({bus.read, bus.write} !== 2'b10) begin errors++; $display("FAIL wl_rw: got %b expected 10", {bus.read, bus.write}); end
        checks++; if (bus.address !== 30'h4) begin errors++; $display("FAIL wl_addr: got %h expected 4", bus.address); end
        checks++; if (bus.byte_enable !== 4'b1111) begin errors++; $display("FAIL wl_be: got %b expected 1111", bus.byte_enable); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wl_ready_busy: got %b expected 0", req_ready); end
        slave(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step();
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wl_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wl_rdata: got %h expected deadbeef", rsp_rdata); end
        checks++; if ({rsp_error, rsp_intercepted} !== 2'b00) begin errors++; $display("FAIL wl_err_icpt: got %b expected 00", {rsp_error, rsp_intercepted}); end
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL wl_read_drop: got %b expected 0", bus.read); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wl_pulse: got valid %b ready %b expected 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_byte_load();
        logic [31:0] exp_r [2];
        exp_r[0] = 32'hFFFF_FF80;
        exp_r[1] = 32'h0000_0080;
        for (int u = 0; u < 2; u++) begin
            issue(1'b0, 32'h0000_0013, 2'd0, u[0], 32'h0);
            checks++; if (bus.byte_enable !== 4'b1000 || bus.address !== 30'h4) begin errors++; $display("FAIL bl_be_addr%0d: got %b/%h expected 1000/4", u, bus.byte_enable, bus.address); end
            slave(1'b1, 1'b0, 1'b1, 32'h8012_3456);
            step();
            slave(1'b0, 1'b0, 1'b0, 32'h0);
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_r[u]) begin errors++; $display("FAIL bl_rdata%0d: got %b/%h expected 1/%h", u, rsp_valid, rsp_rdata, exp_r[u]); end
            step();
        end
    endtask

    task automatic test_half_store_wait();
        issue(1'b1, 32'h0000_0022, 2'd1, 1'b0, 32'h0000_ABCD);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) slave(1'b1, 1'b0, 1'b0, 32'h0);
            checks++; if ({bus.read, bus.write} !== 2'b01 || bus.address !== 30'h8) begin errors++; $display("FAIL hs_rw_addr%0d: got %b/%h expected 01/8", c, {bus.read, bus.write}, bus.address); end
            checks++; if (bus.byte_enable !== 4'b1100 || bus.data !== 32'hABCD_0000) begin errors++; $display("FAIL hs_be_data%0d: got %b/%h expected 1100/abcd0000", c, bus.byte_enable, bus.data); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hs_early%0d: got %b expected 0", c, rsp_valid); end
            step();
        end
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL hs_rsp: got %b/%b/%h expected 1/0/0", rsp_valid, rsp_error, rsp_rdata); end
        checks++; if (bus.write !== 1'b0 || bus.byte_enable !== 4'h0) begin errors++; $display("FAIL hs_idle_bus: got %b/%b expected 0/0000", bus.write, bus.byte_enable); end
        step();
    endtask

    task automatic test_misaligned();
`ifdef ARILLA_BUS_MASTER_MISALIGNED_SPLIT_EN
        issue(1'b0, 32'h0000_0007, 2'd2, 1'b0, 32'h0);
        checks++; if (bus.read !== 1'b1 || bus.address !== 30'h1 || bus.byte_enable !== 4'b1000) begin errors++; $display("FAIL sp_first: got %b/%h/%b expected 1/1/1000", bus.read, bus.address, bus.byte_enable); end
        slave(1'b1, 1'b0, 1'b1, 32'hAABB_CCDD);
        step();
        slave(1'b1, 1'b0, 1'b1, 32'h1122_3344);
        checks++; if (bus.read !== 1'b1 || bus.address !== 30'h2 || bus.byte_enable !== 4'b0111) begin errors++; $display("FAIL sp_second: got %b/%h/%b expected 1/2/0111", bus.read, bus.address, bus.byte_enable); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sp_early: got %b expected 0", rsp_valid); end
        step();
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h2233_44AA) begin errors++; $display("FAIL sp_rsp: got %b/%b/%h expected 1/0/223344aa", rsp_valid, rsp_error, rsp_rdata); end
        step();
`else
        issue(1'b0, 32'h0000_0007, 2'd2, 1'b0, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL ma_word: got %b/%b/%h expected 1/1/0", rsp_valid, rsp_error, rsp_rdata); end
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL ma_no_read: got %b expected 0", bus.read); end
        step();
        issue(1'b1, 32'h0000_0021, 2'd1, 1'b0, 32'h1234);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || bus.write !== 1'b0) begin errors++; $display("FAIL ma_half: got %b/%b/%b expected 1/1/0", rsp_valid, rsp_error, bus.write); end
        step();
`endif
        issue(1'b0, 32'h0000_0000, 2'd3, 1'b0, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || bus.read !== 1'b0) begin errors++; $display("FAIL illegal_size: got %b/%b/%b expected 1/1/0", rsp_valid, rsp_error, bus.read); end
        step();
    endtask

    task automatic test_timeout();
        issue(1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.read !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_hold%0d: got read %b valid %b expected 1 0", c, bus.read, rsp_valid); end
            step();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp: got %b/%b/%h expected 1/1/0", rsp_valid, rsp_error, rsp_rdata); end
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL to_read_drop: got %b expected 0", bus.read); end
        step();
    endtask

    task automatic test_intercept();
        issue(1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'h0);
        slave(1'b1, 1'b1, 1'b1, 32'h1234_5678);
        step();
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_intercepted !== 1'b1 || rsp_error !== 1'b0) begin errors++; $display("FAIL ic_flags: got %b/%b/%b expected 1/1/0", rsp_valid, rsp_intercepted, rsp_error); end
        checks++; if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ic_rdata: got %h expected 12345678", rsp_rdata); end
        step();
    endtask

    task automatic test_reset_mid_access();
        issue(1'b0, 32'h0000_0030, 2'd2, 1'b0, 32'h0);
        checks++; if (bus.read !== 1'b1) begin errors++; $display("FAIL rm_read: got %b expected 1", bus.read); end
        rst = 1'b1;
        slave(1'b1, 1'b0, 1'b1, 32'h5555_AAAA);
        step();
        rst = 1'b0;
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if ({bus.read, bus.write} !== 2'b00 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_drop: got rw %b ready %b expected 00 1", {bus.read, bus.write}, req_ready); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp%0d: got %b expected 0", c, rsp_valid); end
            step();
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
        slave(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store_wait();
        test_misaligned();
        test_timeout();
        test_intercept();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
